// File: rtl/riscorvo_mem_arbiter.sv
// Purpose: merge split instruction/data request ports onto one picorv32-style memory port.
// Latency: grant -> mem_valid_o next cycle; mem_ready_i -> ready_*_o next cycle (>= 2 cycles total).
// Backpressure: one transaction outstanding; requesters hold valid+payload until their ready pulse.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   valid/addr_instr_i        fetch request; ready_instr_o pulses with data_instr_o on completion
//   valid/addr/write_data_i,  data request (read_write_i=1 write, mask_data_i byte enables);
//   read_write_i, mask_data_i ready_data_o pulses with read_data_o on completion
//   mem_*_o / mem_*_i         registered downstream request, mem_ready_i/mem_rdata_i completion
module riscorvo_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_instr_i,
    output logic                    ready_instr_o,
    input  logic [ADDR_WIDTH-1:0]   addr_instr_i,
    output logic [DATA_WIDTH-1:0]   data_instr_o,
    input  logic                    valid_data_i,
    output logic                    ready_data_o,
    input  logic [ADDR_WIDTH-1:0]   addr_data_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    input  logic                    read_write_i,
    input  logic [DATA_WIDTH/8-1:0] mask_data_i,
    output logic [DATA_WIDTH-1:0]   read_data_o,
    output logic                    mem_valid_o,
    output logic                    mem_instr_o,
    input  logic                    mem_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam int STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int STREAK_WIDTH = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    typedef struct packed {
        logic                  instr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } mem_req_t;

    state_t                  state_q, state_d;
    logic [STREAK_WIDTH-1:0] streak_q, streak_d;
    mem_req_t                req_q, req_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    instr_turn;
    logic                    grant_instr, grant_data;
    logic                    capture_instr, capture_data;

    // Data wins a tie unless it has already taken MAX_DATA_STREAK grants in a
    // row while a fetch was waiting; then the fetch goes next.
    assign instr_turn    = valid_instr_i && (!valid_data_i || (streak_q == STREAK_MAX));
    assign grant_instr   = (state_q == IDLE) && instr_turn;
    assign grant_data    = (state_q == IDLE) && valid_data_i && !instr_turn;
    assign capture_instr = (state_q == BUSY_I) && mem_ready_i;
    assign capture_data  = (state_q == BUSY_D) && mem_ready_i;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_ready_i outside BUSY_x is ignored by construction
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_instr) begin
                    state_d = BUSY_I;
                end else if (grant_data) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered downstream request and streak.
    // Payload is only loaded on a grant, so it is frozen while mem_valid_o is high.
    always_comb begin
        req_d       = req_q;
        streak_d    = streak_q;
        mem_valid_d = mem_valid_q;
        if (grant_instr) begin
            req_d.instr = 1'b1;
            req_d.addr  = addr_instr_i;
            req_d.wdata = '0;
            req_d.wstrb = '0;
            streak_d    = '0;
            mem_valid_d = 1'b1;
        end else if (grant_data) begin
            req_d.instr = 1'b0;
            req_d.addr  = addr_data_i;
            req_d.wdata = write_data_i;
            req_d.wstrb = read_write_i ? mask_data_i : '0;
            if (!valid_instr_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + STREAK_WIDTH'(1);
            end
            mem_valid_d = 1'b1;
        end else if (capture_instr || capture_data) begin
            mem_valid_d = 1'b0;
        end
    end

    // Datapath registers; ready pulses land in the RESP cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q         <= '0;
            streak_q      <= '0;
            mem_valid_q   <= 1'b0;
            ready_instr_o <= 1'b0;
            ready_data_o  <= 1'b0;
            data_instr_o  <= '0;
            read_data_o   <= '0;
        end else begin
            req_q         <= req_d;
            streak_q      <= streak_d;
            mem_valid_q   <= mem_valid_d;
            ready_instr_o <= capture_instr;
            ready_data_o  <= capture_data;
            if (capture_instr) begin
                data_instr_o <= mem_rdata_i;
            end
            if (capture_data) begin
                read_data_o <= mem_rdata_i;
            end
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign mem_instr_o = req_q.instr;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_wstrb_o = req_q.wstrb;

endmodule

// File: tb/tb_riscorvo_mem_arbiter.sv
// Purpose: self-checking bench for riscorvo_mem_arbiter (directed scenarios + random traffic).
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: bench plays both requesters and the downstream memory, including ready delays.
module tb_riscorvo_mem_arbiter;
    localparam int MAXS = 4;

    logic        clock;
    logic        reset;
    logic        valid_instr_i;
    logic        ready_instr_o;
    logic [31:0] addr_instr_i;
    logic [31:0] data_instr_o;
    logic        valid_data_i;
    logic        ready_data_o;
    logic [31:0] addr_data_i;
    logic [31:0] write_data_i;
    logic        read_write_i;
    logic [3:0]  mask_data_i;
    logic [31:0] read_data_o;
    logic        mem_valid_o;
    logic        mem_instr_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    riscorvo_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clock(clock), .reset(reset),
        .valid_instr_i(valid_instr_i), .ready_instr_o(ready_instr_o),
        .addr_instr_i(addr_instr_i), .data_instr_o(data_instr_o),
        .valid_data_i(valid_data_i), .ready_data_o(ready_data_o),
        .addr_data_i(addr_data_i), .write_data_i(write_data_i),
        .read_write_i(read_write_i), .mask_data_i(mask_data_i),
        .read_data_o(read_data_o),
        .mem_valid_o(mem_valid_o), .mem_instr_o(mem_instr_o),
        .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        tests++;
        if ({mem_valid_o, mem_instr_o, ready_instr_o, ready_data_o} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_valid_o, mem_instr_o, ready_instr_o, ready_data_o});
        end
        tests++;
        if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 68'h0) begin
            fails++;
            $display("FAIL reset_payload: got %h/%h/%h want 0", mem_addr_o, mem_wdata_o, mem_wstrb_o);
        end
        tests++;
        if ({data_instr_o, read_data_o} !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h want 0", data_instr_o, read_data_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        valid_instr_i = 1'b1;
        addr_instr_i  = 32'h100;
        tick();
        tests++;
        if ({mem_valid_o, mem_instr_o, mem_wstrb_o, mem_addr_o} !== {1'b1, 1'b1, 4'h0, 32'h100}) begin
            fails++;
            $display("FAIL fetch_issue: got v=%b i=%b s=%h a=%h want 1 1 0 100", mem_valid_o, mem_instr_o, mem_wstrb_o, mem_addr_o);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h0000_0013;
        tick();
        mem_ready_i = 1'b0;
        tests++;
        if ({ready_instr_o, ready_data_o, mem_valid_o, data_instr_o} !== {3'b100, 32'h13}) begin
            fails++;
            $display("FAIL fetch_resp: got r=%b%b v=%b d=%h want 10 0 00000013", ready_instr_o, ready_data_o, mem_valid_o, data_instr_o);
        end
        tick();
        valid_instr_i = 1'b0;
        tests++;
        if (ready_instr_o !== 1'b0) begin
            fails++;
            $display("FAIL fetch_pulse_width: got %b want 0", ready_instr_o);
        end
        tick();
    endtask

    task automatic test_write();
        valid_data_i = 1'b1;
        addr_data_i  = 32'h2000;
        write_data_i = 32'hDEAD_BEEF;
        read_write_i = 1'b1;
        mask_data_i  = 4'h3;
        tick();
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({mem_valid_o, mem_instr_o, mem_wstrb_o, mem_wdata_o, mem_addr_o, ready_data_o}
                    !== {1'b1, 1'b0, 4'h3, 32'hDEAD_BEEF, 32'h2000, 1'b0}) begin
                fails++;
                $display("FAIL write_hold[%0d]: got v=%b i=%b s=%h w=%h a=%h r=%b want 1 0 3 deadbeef 2000 0",
                         k, mem_valid_o, mem_instr_o, mem_wstrb_o, mem_wdata_o, mem_addr_o, ready_data_o);
            end
            tick();
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h0BAD_F00D;
        tick();
        mem_ready_i = 1'b0;
        tests++;
        if ({ready_data_o, ready_instr_o, mem_valid_o, read_data_o} !== {3'b100, 32'h0BAD_F00D}) begin
            fails++;
            $display("FAIL write_resp: got r=%b%b v=%b d=%h want 10 0 0badf00d", ready_data_o, ready_instr_o, mem_valid_o, read_data_o);
        end
        tick();
        valid_data_i = 1'b0;
        read_write_i = 1'b0;
        tests++;
        if (ready_data_o !== 1'b0) begin
            fails++;
            $display("FAIL write_pulse_width: got %b want 0", ready_data_o);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [9:0] exp_i = 10'b10_0001_0000;   // grant k is a fetch when bit k set
        int w;
        valid_instr_i = 1'b1;
        addr_instr_i  = 32'h400;
        valid_data_i  = 1'b1;
        addr_data_i   = 32'h800;
        read_write_i  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w = 0;
            while (mem_valid_o !== 1'b1 && w < 8) begin
                tick();
                w++;
            end
            tests++;
            if (mem_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL contention_timeout[%0d]: got no mem_valid_o want grant", k);
                break;
            end
            tests++;
            if (mem_instr_o !== exp_i[k]) begin
                fails++;
                $display("FAIL contention_order[%0d]: got instr=%b want %b", k, mem_instr_o, exp_i[k]);
            end
            mem_ready_i = 1'b1;
            mem_rdata_i = $urandom;
            tick();
            mem_ready_i = 1'b0;
            tests++;
            if ({ready_instr_o, ready_data_o} !== {exp_i[k], ~exp_i[k]}) begin
                fails++;
                $display("FAIL contention_ready[%0d]: got %b%b want %b%b", k, ready_instr_o, ready_data_o, exp_i[k], ~exp_i[k]);
            end
            tick();
        end
        valid_instr_i = 1'b0;
        valid_data_i  = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        valid_instr_i = 1'b1;
        addr_instr_i  = 32'h500;
        valid_data_i  = 1'b1;
        addr_data_i   = 32'h600;
        read_write_i  = 1'b0;
        tick();
        tests++;
        if ({mem_valid_o, mem_instr_o, mem_addr_o} !== {2'b10, 32'h600}) begin
            fails++;
            $display("FAIL simul_first: got v=%b i=%b a=%h want 1 0 600", mem_valid_o, mem_instr_o, mem_addr_o);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h55;
        tick();
        mem_ready_i = 1'b0;
        tests++;
        if ({ready_data_o, read_data_o} !== {1'b1, 32'h55}) begin
            fails++;
            $display("FAIL simul_data_resp: got r=%b d=%h want 1 00000055", ready_data_o, read_data_o);
        end
        tick();
        valid_data_i = 1'b0;
        tick();
        tests++;
        if ({mem_valid_o, mem_instr_o, mem_addr_o} !== {2'b11, 32'h500}) begin
            fails++;
            $display("FAIL simul_second: got v=%b i=%b a=%h want 1 1 500", mem_valid_o, mem_instr_o, mem_addr_o);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h66;
        tick();
        mem_ready_i = 1'b0;
        tests++;
        if ({ready_instr_o, data_instr_o} !== {1'b1, 32'h66}) begin
            fails++;
            $display("FAIL simul_instr_resp: got r=%b d=%h want 1 00000066", ready_instr_o, data_instr_o);
        end
        tick();
        valid_instr_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        valid_data_i = 1'b1;
        addr_data_i  = 32'h3000;
        write_data_i = 32'h1234_5678;
        read_write_i = 1'b1;
        mask_data_i  = 4'hF;
        tick();
        tests++;
        if (mem_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_issue: got %b want 1", mem_valid_o);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({mem_valid_o, ready_data_o} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_async: got v=%b r=%b want 0 0", mem_valid_o, ready_data_o);
        end
        tick();
        tests++;
        if ({mem_valid_o, ready_data_o} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_held: got v=%b r=%b want 0 0", mem_valid_o, ready_data_o);
        end
        reset = 1'b0;
        tick();
        tests++;
        if ({mem_valid_o, mem_instr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, ready_data_o}
                !== {2'b10, 4'hF, 32'h3000, 32'h1234_5678, 1'b0}) begin
            fails++;
            $display("FAIL rstmid_reissue: got v=%b i=%b s=%h a=%h w=%h r=%b want 1 0 f 3000 12345678 0",
                     mem_valid_o, mem_instr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, ready_data_o);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h77;
        tick();
        mem_ready_i = 1'b0;
        tests++;
        if ({ready_data_o, read_data_o} !== {1'b1, 32'h77}) begin
            fails++;
            $display("FAIL rstmid_resp: got r=%b d=%h want 1 00000077", ready_data_o, read_data_o);
        end
        tick();
        valid_data_i = 1'b0;
        read_write_i = 1'b0;
        tick();
    endtask

    task automatic test_spurious_ready();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hBAD0_0BAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({mem_valid_o, ready_instr_o, ready_data_o} !== 3'b000) begin
                fails++;
                $display("FAIL spurious_idle[%0d]: got %b want 000", k, {mem_valid_o, ready_instr_o, ready_data_o});
            end
        end
        // fetch data was cleared by the mid-transaction reset; load data is the last capture
        tests++;
        if ({data_instr_o, read_data_o} !== {32'h0, 32'h77}) begin
            fails++;
            $display("FAIL spurious_capture: got %h/%h want 00000000/00000077", data_instr_o, read_data_o);
        end
        mem_ready_i   = 1'b0;
        valid_instr_i = 1'b1;
        addr_instr_i  = 32'h900;
        tick();
        tests++;
        if ({mem_valid_o, mem_instr_o, mem_addr_o} !== {2'b11, 32'h900}) begin
            fails++;
            $display("FAIL spurious_after: got v=%b i=%b a=%h want 1 1 900", mem_valid_o, mem_instr_o, mem_addr_o);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h99;
        tick();
        mem_ready_i = 1'b0;
        tests++;
        if ({ready_instr_o, data_instr_o} !== {1'b1, 32'h99}) begin
            fails++;
            $display("FAIL spurious_after_resp: got r=%b d=%h want 1 00000099", ready_instr_o, data_instr_o);
        end
        tick();
        valid_instr_i = 1'b0;
        tick();
    endtask

    // Random traffic against a timestamp model: a grant in cycle g shows mem_valid_o
    // from g+1 until the accept cycle r, the ready pulse comes at r+1, and the next
    // grant may happen at r+2 or later.
    task automatic test_random();
        bit          inflight = 1'b0;
        bit          g_instr = 1'b0;
        int          next_grant = cyc;
        int          exp_issue = 0;
        int          accept = -1;
        int          streak = 0;
        int          grants = 0;
        bit          exp_v, exp_p, waiting;
        bit          i_act = 1'b0, d_act = 1'b0, i_rel = 1'b0, d_rel = 1'b0;
        logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
        bit          d_rw = 1'b0;
        logic [3:0]  d_mask = '0;
        logic        e_instr = 1'b0;
        logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
        logic [3:0]  e_wstrb = '0;
        for (int k = 0; k < 3000; k++) begin
            if (i_rel) begin i_act = 1'b0; i_rel = 1'b0; end
            if (d_rel) begin d_act = 1'b0; d_rel = 1'b0; end

            exp_v = inflight && cyc >= exp_issue && (accept < 0 || cyc <= accept);
            exp_p = inflight && accept >= 0 && cyc == accept + 1;
            tests++;
            if ({mem_valid_o, ready_instr_o, ready_data_o} !== {exp_v, exp_p && g_instr, exp_p && !g_instr}) begin
                fails++;
                $display("FAIL rand_ctrl@%0d: got v=%b ri=%b rd=%b want %b %b %b", cyc, mem_valid_o,
                         ready_instr_o, ready_data_o, exp_v, exp_p && g_instr, exp_p && !g_instr);
            end
            if (exp_v) begin
                tests++;
                if ({mem_instr_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {e_instr, e_addr, e_wdata, e_wstrb}) begin
                    fails++;
                    $display("FAIL rand_payload@%0d: got i=%b a=%h w=%h s=%h want %b %h %h %h", cyc, mem_instr_o,
                             mem_addr_o, mem_wdata_o, mem_wstrb_o, e_instr, e_addr, e_wdata, e_wstrb);
                end
            end
            if (exp_p) begin
                tests++;
                if ((g_instr ? data_instr_o : read_data_o) !== e_rdata) begin
                    fails++;
                    $display("FAIL rand_rdata@%0d: got %h want %h", cyc, g_instr ? data_instr_o : read_data_o, e_rdata);
                end
                inflight   = 1'b0;
                next_grant = cyc + 1;
                if (g_instr) i_rel = 1'b1;
                else         d_rel = 1'b1;
            end

            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act   = 1'b1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_rw    = 1'($urandom_range(0, 1));
                d_mask  = 4'($urandom_range(0, 15));
            end

            waiting = inflight && cyc >= exp_issue && accept < 0;
            mem_rdata_i = $urandom;
            if (waiting) begin
                mem_ready_i = ($urandom_range(0, 2) == 0);
                if (mem_ready_i) begin
                    accept  = cyc;
                    e_rdata = mem_rdata_i;
                end
            end else begin
                mem_ready_i = ($urandom_range(0, 7) == 0);
            end

            if (!inflight && cyc >= next_grant && (i_act || d_act)) begin
                g_instr = i_act && (!d_act || streak == MAXS);
                if (g_instr)    streak = 0;
                else if (i_act) streak = (streak < MAXS) ? streak + 1 : MAXS;
                else            streak = 0;
                e_instr   = g_instr;
                e_addr    = g_instr ? i_addr : d_addr;
                e_wdata   = g_instr ? 32'h0 : d_wdata;
                e_wstrb   = (!g_instr && d_rw) ? d_mask : 4'h0;
                inflight  = 1'b1;
                exp_issue = cyc + 1;
                accept    = -1;
                grants++;
            end

            valid_instr_i = i_act;
            addr_instr_i  = i_act ? i_addr : $urandom;
            valid_data_i  = d_act;
            addr_data_i   = d_act ? d_addr : $urandom;
            write_data_i  = d_act ? d_wdata : $urandom;
            read_write_i  = d_act ? d_rw : 1'($urandom_range(0, 1));
            mask_data_i   = d_act ? d_mask : 4'($urandom_range(0, 15));
            tick();
        end
        tests++;
        if (grants < 100) begin
            fails++;
            $display("FAIL rand_activity: got %0d grants want at least 100", grants);
        end
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b1;
        valid_instr_i = 1'b0;
        addr_instr_i  = '0;
        valid_data_i  = 1'b0;
        addr_data_i   = '0;
        write_data_i  = '0;
        read_write_i  = 1'b0;
        mask_data_i   = '0;
        mem_ready_i   = 1'b0;
        mem_rdata_i   = '0;
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_simultaneous();
        test_reset_mid();
        test_spurious_ready();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got no completion by time %0t want finish", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
